// File: rtl/fpu_req_arbiter_pkg.sv
// Shared constants and types for the FP adder request arbiter slice:
// number format, core status codes and the arbiter state encoding.
package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_OVF     = 4'b0011;
  localparam logic [3:0] ST_UNF     = 4'b0111;
  localparam logic [3:0] ST_INEXACT = 4'b1111;
  localparam logic [3:0] ST_TIMEOUT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Requester and FP core signals seen by the arbiter. The slave modport is the
// arbiter; the master modport is the requester/core side that surrounds it.
interface fpu_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  // Requester i offers work by holding req_valid[i] and its operand slices;
  // the transfer happens on the cycle where req_valid[i] and req_ready[i] are
  // both high. rsp_valid[i] is a one-cycle pulse with no back-pressure, and
  // fpu_start / fpu_done are one-cycle pulses between arbiter and core.
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_op_a;
  logic [32*NUM_REQ-1:0] req_op_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_status;
  logic                  fpu_start;
  logic [31:0]           fpu_op_a;
  logic [31:0]           fpu_op_b;
  logic                  fpu_done;
  logic [31:0]           fpu_result;
  logic [3:0]            fpu_status;

  modport slave (
    input  req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_status,
           fpu_start, fpu_op_a, fpu_op_b
  );

  modport master (
    output req_valid, req_op_a, req_op_b, fpu_done, fpu_result, fpu_status,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_status,
           fpu_start, fpu_op_a, fpu_op_b
  );

endinterface

// File: rtl/fpu_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// around, wins. Produces a one-hot grant, its index and an any-request flag.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP adder among NUM_REQ requesters.
// Optional watchdog on the core's done pulse: define FPU_ARB_TIMEOUT_EN.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  fpu_req_arbiter_if.slave   bus,
  output arb_state_t         state
);

  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2)
  begin : g_bad_cfg
    $error("fpu_req_arbiter: inconsistent parameters");
  end

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [ID_W-1:0]    next_ptr;
  logic [ID_W+4:0]    pick_base;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  // Ready is combinational so the handshake completes in the cycle it is offered.
  assign bus.req_ready = (state == IDLE && reset) ? pick_grant : '0;
  assign next_ptr      = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
  assign pick_base     = {pick_id, 5'd0};

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  // The count includes the start cycle, so the response lands TIMEOUT_CYCLES after start.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= '0;
      grant_id       <= '0;
      bus.rsp_valid  <= '0;
      bus.rsp_id     <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= '0;
      bus.fpu_start  <= 1'b0;
      bus.fpu_op_a   <= '0;
      bus.fpu_op_b   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= '0;
          if (pick_any) begin
            bus.fpu_op_a  <= bus.req_op_a[pick_base +: 32];
            bus.fpu_op_b  <= bus.req_op_b[pick_base +: 32];
            grant_id      <= pick_id;
            ptr           <= next_ptr;
            bus.fpu_start <= 1'b1;
            state         <= ISSUE;
`ifdef FPU_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          // A done seen here belongs to nothing we issued and is dropped.
          bus.fpu_start <= 1'b0;
          state         <= WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt      <= wait_cnt + 1'b1;
`endif
        end
        WAIT: begin
          if (bus.fpu_done) begin
            bus.rsp_data   <= bus.fpu_result;
            bus.rsp_status <= bus.fpu_status;
            bus.rsp_valid  <= NUM_REQ'(1) << grant_id;
            bus.rsp_id     <= grant_id;
            state          <= RESP;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (timed_out) begin
            bus.rsp_data   <= '0;
            bus.rsp_status <= ST_TIMEOUT;
            bus.rsp_valid  <= NUM_REQ'(1) << grant_id;
            bus.rsp_id     <= grant_id;
            state          <= RESP;
          end else begin
            wait_cnt       <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          bus.rsp_valid <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: reset values, single op, contention order,
// pointer wrap, reset during WAIT, status passthrough and (optionally) timeout.
module tb_fpu_req_arbiter;
  import fpu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic       clock;
  logic       reset;
  arb_state_t state;
  int         checks;
  int         errors;

  fpu_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fpu_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .state (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_op_a[32*id +: 32] = a;
    bus.req_op_b[32*id +: 32] = b;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.fpu_done  = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // One full transaction; called at an IDLE cycle with the winner's valid high.
  task automatic run_op(input int id, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] res, input logic [3:0] st, input int dly,
                        input bit early_done, input bit drop);
    logic [NUM_REQ-1:0] oh;
    oh = 4'b0001 << id;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(oh));
    step();
    if (drop) bus.req_valid[id] = 1'b0;
    chk("fpu_start", 64'(bus.fpu_start), 64'd1);
    chk("fpu_op_a", 64'(bus.fpu_op_a), 64'(ea));
    chk("fpu_op_b", 64'(bus.fpu_op_b), 64'(eb));
    if (early_done) begin
      bus.fpu_done   = 1'b1;
      bus.fpu_result = 32'hDEAD_BEEF;
      bus.fpu_status = 4'hF;
    end
    step();
    bus.fpu_done = 1'b0;
    chk("start_pulse", 64'(bus.fpu_start), 64'd0);
    chk("ready_busy", 64'(bus.req_ready), 64'd0);
    chk("state_wait", 64'(state), 64'(WAIT));
    for (int k = 1; k < dly; k++) step();
    chk("op_a_hold", 64'(bus.fpu_op_a), 64'(ea));
    bus.fpu_done   = 1'b1;
    bus.fpu_result = res;
    bus.fpu_status = st;
    step();
    bus.fpu_done = 1'b0;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
    chk("rsp_id", 64'(bus.rsp_id), 64'(id));
    chk("rsp_data", 64'(bus.rsp_data), 64'(res));
    chk("rsp_status", 64'(bus.rsp_status), 64'(st));
    step();
    chk("rsp_valid_end", 64'(bus.rsp_valid), 64'd0);
    chk("rsp_data_hold", 64'(bus.rsp_data), 64'(res));
  endtask

  // driver / main sequence
  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b0;
    bus.req_valid  = '0;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.fpu_done   = 1'b0;
    bus.fpu_result = '0;
    bus.fpu_status = '0;
    step();
    step();

    // Reset values, including no ready while reset is held.
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_status", 64'(bus.rsp_status), 64'd0);
    chk("rst_fpu_start", 64'(bus.fpu_start), 64'd0);
    chk("rst_fpu_op_a", 64'(bus.fpu_op_a), 64'd0);
    chk("rst_fpu_op_b", 64'(bus.fpu_op_b), 64'd0);
    chk("rst_state", 64'(state), 64'(IDLE));
    bus.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    reset = 1'b1;
    step();
    step();
    chk("idle_state", 64'(state), 64'(IDLE));

    // Single request: 1.0 + 1.0 = 2.0.
    set_ops(0, 32'h3E00_0000, 32'h3E00_0000);
    bus.req_valid = 4'b0001;
    run_op(0, 32'h3E00_0000, 32'h3E00_0000, 32'h4000_0000, ST_EXACT, 2, 1'b0, 1'b1);

    // Status passthrough, with a stray done during ISSUE on the first op.
    set_ops(2, 32'h0123_4567, 32'h89AB_CDEF);
    bus.req_valid = 4'b0100;
    run_op(2, 32'h0123_4567, 32'h89AB_CDEF, 32'h0000_0000, ST_UNF, 3, 1'b1, 1'b1);
    set_ops(1, 32'h3E40_0000, 32'h3C00_0001);
    bus.req_valid = 4'b0010;
    run_op(1, 32'h3E40_0000, 32'h3C00_0001, 32'h3E40_0001, ST_INEXACT, 4, 1'b0, 1'b1);

    // Reset while waiting on the core: no response, late done ignored.
    do_reset();
    set_ops(0, 32'h1111_1111, 32'h2222_2222);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    chk("rw_start", 64'(bus.fpu_start), 64'd1);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rw_state", 64'(state), 64'(IDLE));
    chk("rw_op_a", 64'(bus.fpu_op_a), 64'd0);
    chk("rw_start_clr", 64'(bus.fpu_start), 64'd0);
    step();
    reset = 1'b1;
    step();
    bus.fpu_done   = 1'b1;
    bus.fpu_result = 32'h1234_5678;
    bus.fpu_status = ST_OVF;
    step();
    bus.fpu_done = 1'b0;
    chk("rw_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rw_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rw_state_idle", 64'(state), 64'(IDLE));
    step();
    chk("rw_no_rsp2", 64'(bus.rsp_valid), 64'd0);

    // Contention from ptr=0: grants 0,1,2,3,0,1,2 with all four held valid.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++)
      set_ops(i, 32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i));
    bus.req_valid = 4'hF;
    run_op(0, 32'hA000_0000, 32'hB000_0000, 32'h4000_0000, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(1, 32'hA000_0001, 32'hB000_0001, 32'h4000_0001, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(2, 32'hA000_0002, 32'hB000_0002, 32'h4000_0002, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(3, 32'hA000_0003, 32'hB000_0003, 32'h4000_0003, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(0, 32'hA000_0000, 32'hB000_0000, 32'h4000_0010, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(1, 32'hA000_0001, 32'hB000_0001, 32'h4000_0011, ST_EXACT, 5, 1'b0, 1'b0);
    run_op(2, 32'hA000_0002, 32'hB000_0002, 32'h4000_0012, ST_EXACT, 5, 1'b0, 1'b0);

    // Pointer now at 3: 1001 grants 3 first, then wraps to 0.
    bus.req_valid = 4'b1001;
    run_op(3, 32'hA000_0003, 32'hB000_0003, 32'h4000_0023, ST_OVF, 2, 1'b0, 1'b1);
    run_op(0, 32'hA000_0000, 32'hB000_0000, 32'h4000_0020, ST_EXACT, 2, 1'b0, 1'b1);

`ifdef FPU_ARB_TIMEOUT_EN
    // Core never answers: timeout response TO cycles after start.
    bus.fpu_result = 32'hFFFF_FFFF;
    bus.fpu_status = ST_INEXACT;
    bus.req_valid  = 4'b0010;
    #1;
    chk("to_ready", 64'(bus.req_ready), 64'b0010);
    step();
    bus.req_valid = '0;
    chk("to_start", 64'(bus.fpu_start), 64'd1);
    for (int k = 1; k < TO; k++) step();
    chk("to_not_early", 64'(bus.rsp_valid), 64'd0);
    step();
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'b0010);
    chk("to_rsp_status", 64'(bus.rsp_status), 64'(ST_TIMEOUT));
    chk("to_rsp_data", 64'(bus.rsp_data), 64'd0);
    step();
    bus.req_valid = 4'b0010;
    run_op(1, 32'hA000_0001, 32'hB000_0001, 32'h3E00_0000, ST_EXACT, 3, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
